// File: rtl/program_loader_pkg.sv
// Shared constants and loader state encoding for the program loader and
// the processor decoder that consumes the same instruction widths.
package program_loader_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StHi   = 3'd1,
        StLo   = 3'd2,
        StChk  = 3'd3,
        StDone = 3'd4,
        StErr  = 3'd5
    } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream, control and fetch-port signals between the host/processor
// side (master) and the program loader (slave).
interface program_loader_if;
    import program_loader_pkg::*;

    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_instruction;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, rx_data, rx_valid, fetch_addr,
        input  rx_ready, fetch_instruction, cpu_hold, done, error
    );

    modport slave (
        input  start, rx_data, rx_valid, fetch_addr,
        output rx_ready, fetch_instruction, cpu_hold, done, error
    );

endinterface

// File: rtl/program_loader_inst_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// No reset; contents survive rst. A read of the address being written sees
// the old word until the write edge.
module program_loader_inst_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Loads DEPTH instruction words from a high-byte-first byte stream followed
// by an XOR checksum byte, stalling the processor while loading, and serves
// the processor's combinational fetch port from the loaded RAM.
module program_loader
    import program_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);

    loader_state_e     state;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        csum;
    logic              done;
    logic              error;

    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Loader FSM with its datapath registers and the done/error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            hi_byte <= 8'h00;
            wr_addr <= '0;
            csum    <= 8'h00;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone, StErr: begin
                    if (bus.start) begin
                        wr_addr <= '0;
                        csum    <= 8'h00;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        state   <= StHi;
                    end
                end
                StHi: begin
                    if (bus.rx_valid) begin
                        hi_byte <= bus.rx_data;
                        csum    <= csum ^ bus.rx_data;
                        state   <= StLo;
                    end
                end
                StLo: begin
                    if (bus.rx_valid) begin
                        csum    <= csum ^ bus.rx_data;
                        // Wraps after the last word; the FSM leaves for StChk first.
                        wr_addr <= wr_addr + ADDR_W'(1);
                        if (wr_addr == ADDR_W'(DEPTH - 1)) begin
                            state <= StChk;
                        end else begin
                            state <= StHi;
                        end
                    end
                end
                StChk: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == csum) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            error <= 1'b1;
                            state <= StErr;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Handshake and stall are pure decodes of the state register.
    always_comb begin
        bus.rx_ready = 1'b0;
        bus.cpu_hold = 1'b0;
        unique case (state)
            StHi, StLo, StChk: begin
                bus.rx_ready = 1'b1;
                bus.cpu_hold = 1'b1;
            end
            StErr: begin
                bus.cpu_hold = 1'b1;
            end
            default: begin
                bus.rx_ready = 1'b0;
                bus.cpu_hold = 1'b0;
            end
        endcase
    end

    assign ram_we    = (state == StLo) && bus.rx_valid;
    assign ram_wdata = {hi_byte, bus.rx_data};

    assign bus.done              = done;
    assign bus.error             = error;
    assign bus.fetch_instruction = ram_rdata;

    program_loader_inst_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) inst_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (ram_wdata),
        .raddr (bus.fetch_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader: RAM read-back tables,
// full-rate, gapped, bad-checksum, mid-load reset and same-cycle read/write.
module tb_program_loader;
    import program_loader_pkg::*;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    program_loader_if bus ();

    program_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Table 0: good program, 1: program with word 3 = C800, 2: all zero.
    rd_vec_t    tabs [3][16];
    logic [7:0] stream [33];
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte stream from a table, checksum computed by XOR of all data bytes.
    task automatic build(input int sel, input bit bad);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 16; i++) begin
            stream[2*i]   = tabs[sel][i].exp[15:8];
            stream[2*i+1] = tabs[sel][i].exp[7:0];
            c = c ^ tabs[sel][i].exp[15:8] ^ tabs[sel][i].exp[7:0];
        end
        stream[32] = bad ? ~c : c;
    endtask

    task automatic check_ram(input int sel, input string name);
        for (int i = 0; i < 16; i++) begin
            bus.fetch_addr = tabs[sel][i].addr;
            #1;
            check($sformatf("%s[%0d]", name, i), bus.fetch_instruction, tabs[sel][i].exp);
        end
        @(negedge clk);
    endtask

    task automatic check_idle_flags(input string name, input logic d, input logic e,
                                    input logic h);
        check({name, "_done"}, bus.done, d);
        check({name, "_error"}, bus.error, e);
        check({name, "_hold"}, bus.cpu_hold, h);
        check({name, "_ready"}, bus.rx_ready, 1'b0);
    endtask

    // Start pulse then the 33-byte stream; entered and left at a negedge.
    task automatic run_load(input bit gap, input bit junk, input bit start_hi,
                            input int spy, input logic [15:0] spy_old);
        int ready_cyc;
        int refused;
        int hold_lo;
        ready_cyc = 0;
        refused   = 0;
        hold_lo   = 0;
        bus.start    = 1'b1;
        bus.rx_valid = junk;
        bus.rx_data  = 8'hAA;
        check("start_cycle_ready", bus.rx_ready, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 33; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = stream[i];
            bus.start    = start_hi && (i == 2);
            if (bus.rx_ready) ready_cyc++;
            else refused++;
            if (!bus.cpu_hold) hold_lo++;
            if (spy >= 0 && i == 2 * spy + 1) begin
                bus.fetch_addr = 4'(spy);
                #1;
                check("rw_old_word", bus.fetch_instruction, spy_old);
                @(posedge clk);
                #1;
                check("rw_new_word", bus.fetch_instruction, {stream[2*spy], stream[2*spy+1]});
            end
            @(negedge clk);
            if (gap && i < 32) begin
                bus.rx_valid = 1'b0;
                bus.start    = 1'b0;
                if (bus.rx_ready) ready_cyc++;
                if (!bus.cpu_hold) hold_lo++;
                @(negedge clk);
            end
        end
        bus.rx_valid = 1'b0;
        bus.start    = 1'b0;
        check("ready_cycles", ready_cyc, gap ? 65 : 33);
        check("refused_bytes", refused, 0);
        check("hold_low_cycles", hold_lo, 0);
    endtask

    initial begin
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 16; i++) begin
                tabs[t][i].addr = 4'(i);
                tabs[t][i].exp  = 16'h0000;
            end
        end
        tabs[0][0].exp = 16'h1A0A;
        tabs[0][1].exp = 16'h1C0B;
        tabs[1][0].exp = 16'h1A0A;
        tabs[1][1].exp = 16'h1C0B;
        tabs[1][3].exp = 16'hC800;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.fetch_addr = '0;

        // Reset then idle
        repeat (2) @(negedge clk);
        check_idle_flags("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_flags("idle", 1'b0, 1'b0, 1'b0);
        check_ram(2, "reset_ram");

        // Good load; start arrives with a junk byte in IDLE that must be ignored
        build(0, 1'b0);
        run_load(1'b0, 1'b1, 1'b0, -1, 16'h0000);
        check_idle_flags("good", 1'b1, 1'b0, 1'b0);
        check_ram(0, "good_ram");

        // Bad checksum: error latched and processor stays held
        build(0, 1'b1);
        run_load(1'b0, 1'b0, 1'b0, -1, 16'h0000);
        check_idle_flags("bad", 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_idle_flags("bad_hold", 1'b0, 1'b1, 1'b1);

        // Recovery from ERR with a good load
        build(0, 1'b0);
        run_load(1'b0, 1'b0, 1'b0, -1, 16'h0000);
        check_idle_flags("recover", 1'b1, 1'b0, 1'b0);

        // Clear RAM, then gapped load must rebuild the good image
        build(2, 1'b0);
        run_load(1'b0, 1'b0, 1'b0, -1, 16'h0000);
        check_idle_flags("zero", 1'b1, 1'b0, 1'b0);
        check_ram(2, "zero_ram");
        build(0, 1'b0);
        run_load(1'b1, 1'b0, 1'b0, -1, 16'h0000);
        check_idle_flags("gap", 1'b1, 1'b0, 1'b0);
        check_ram(0, "gap_ram");

        // Reset mid-load after 5 bytes, starting from an all-zero RAM
        build(2, 1'b0);
        run_load(1'b0, 1'b0, 1'b0, -1, 16'h0000);
        build(0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = stream[i];
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        check("midload_hold_before", bus.cpu_hold, 1'b1);
        rst = 1'b1;
        #1;
        check_idle_flags("midload_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_flags("midload_idle", 1'b0, 1'b0, 1'b0);
        bus.fetch_addr = 4'd0;
        #1 check("midload_ram0", bus.fetch_instruction, 16'h1A0A);
        bus.fetch_addr = 4'd1;
        #1 check("midload_ram1", bus.fetch_instruction, 16'h1C0B);
        bus.fetch_addr = 4'd2;
        #1 check("midload_ram2", bus.fetch_instruction, 16'h0000);
        @(negedge clk);

        // start pulsed while in HI must not restart the load
        build(0, 1'b0);
        run_load(1'b0, 1'b0, 1'b1, -1, 16'h0000);
        check_idle_flags("start_in_hi", 1'b1, 1'b0, 1'b0);
        check_ram(0, "start_in_hi_ram");

        // Same-cycle read/write of word 3 (old value 0000, new C800)
        build(1, 1'b0);
        run_load(1'b0, 1'b0, 1'b0, 3, 16'h0000);
        check_idle_flags("rw", 1'b1, 1'b0, 1'b0);
        check_ram(1, "rw_ram");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
